// File: rtl/bitwise_logic_unit.sv
// Sequential bitwise logic unit: single-cycle AND/NAND/OR/NOR/XOR/XNOR, iterative
// population count and rotate-left (one bit per clock), with registered result and flags.
module bitwise_logic_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out1,
    output logic             zero,
    output logic             parity
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_POPCNT = 3'b110;
    localparam logic [2:0] OP_ROTL   = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] out1_q, out1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    bits_q, bits_d;
    logic             rot_q, rot_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;
    logic             done_q, done_d;

    logic             wr;
    logic [WIDTH-1:0] res;
    logic [SHW-1:0]   amt;
    logic [CW-1:0]    pop_next;
    logic [WIDTH-1:0] rot_next;

    assign amt      = y[SHW-1:0];
    assign pop_next = cnt_q + {{(CW-1){1'b0}}, work_q[0]};
    assign rot_next = {work_q[WIDTH-2:0], work_q[WIDTH-1]};

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        bits_d   = bits_q;
        rot_d    = rot_q;
        out1_d   = out1_q;
        wr       = 1'b0;
        res      = out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    out1_d = x & y;
                    if (op == OP_POPCNT) begin
                        work_d  = x;
                        cnt_d   = '0;
                        bits_d  = CW'(WIDTH);
                        rot_d   = 1'b0;
                        state_d = BUSY;
                    end else if (op == OP_ROTL && amt != '0) begin
                        work_d  = x;
                        cnt_d   = '0;
                        bits_d  = CW'(amt);
                        rot_d   = 1'b1;
                        state_d = BUSY;
                    end else begin
                        wr = 1'b1;
                        case (op)
                            3'b000:  res = x & y;
                            3'b001:  res = ~(x & y);
                            3'b010:  res = x | y;
                            3'b011:  res = ~(x | y);
                            3'b100:  res = x ^ y;
                            3'b101:  res = ~(x ^ y);
                            default: res = x;  // ROTL by zero passes x through
                        endcase
                    end
                end
            end
            BUSY: begin
                bits_d = bits_q - 1'b1;
                if (rot_q) begin
                    work_d = rot_next;
                end else begin
                    work_d = work_q >> 1;
                    cnt_d  = pop_next;
                end
                // Final iteration: publish the value produced on this same edge
                if (bits_q == CW'(1)) begin
                    wr      = 1'b1;
                    res     = rot_q ? rot_next : {{(WIDTH-CW){1'b0}}, pop_next};
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        out_d    = wr ? res : out_q;
        zero_d   = wr ? ~|res : zero_q;
        parity_d = wr ? ^res : parity_q;
        done_d   = wr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            bits_q   <= '0;
            rot_q    <= 1'b0;
            out_q    <= '0;
            out1_q   <= '0;
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            bits_q   <= bits_d;
            rot_q    <= rot_d;
            out_q    <= out_d;
            out1_q   <= out1_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
            done_q   <= done_d;
        end
    end

    assign ready  = (state_q == IDLE);
    assign done   = done_q;
    assign out    = out_q;
    assign out1   = out1_q;
    assign zero   = zero_q;
    assign parity = parity_q;
endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Scoreboard bench for bitwise_logic_unit: directed vectors push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_bitwise_logic_unit;
    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         ready;
    logic         done;
    logic [W-1:0] out;
    logic [W-1:0] out1;
    logic         zero;
    logic         parity;

    // Expected tuple: {out, out1, zero, parity}
    logic [2*W+1:0] exp_q[$];
    int vec_cnt = 0;
    int err_cnt = 0;

    bitwise_logic_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .x      (x),
        .y      (y),
        .ready  (ready),
        .done   (done),
        .out    (out),
        .out1   (out1),
        .zero   (zero),
        .parity (parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            logic [2*W+1:0] e;
            vec_cnt++;
            if (exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL unexpected_done: out=%h out1=%h zero=%b parity=%b with nothing expected",
                         out, out1, zero, parity);
            end else begin
                e = exp_q.pop_front();
                if ({out, out1, zero, parity} !== e) begin
                    err_cnt++;
                    $display("FAIL result: got out=%h out1=%h zero=%b parity=%b, expected out=%h out1=%h zero=%b parity=%b",
                             out, out1, zero, parity, e[2*W+1:W+2], e[W+1:2], e[1], e[0]);
                end
            end
        end
    end

    // Present one request for one edge; start is left high for back-to-back use
    task automatic drive(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r, input bit push);
        start = 1'b1;
        op    = o;
        x     = a;
        y     = b;
        if (push) exp_q.push_back({r, a & b, ~|r, ^r});
        @(posedge clk);
        #1;
    endtask

    // Count low-ready cycles until IDLE, bounded
    task automatic wait_idle(input int exp_busy, input string name);
        int n;
        bit seen_idle;
        n = 0;
        seen_idle = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (ready) begin
                seen_idle = 1'b1;
                break;
            end
            n++;
        end
        if (!seen_idle) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL %s_timeout: ready still low after %0d cycles, expected %0d", name, n, exp_busy);
        end else begin
            chk({name, "_busy_cycles"}, W'(n), W'(exp_busy));
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_out"}, out, '0);
        chk({name, "_out1"}, out1, '0);
        chk({name, "_flags"}, W'({done, zero, parity}), '0);
        chk({name, "_ready"}, W'(ready), W'(1));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = '0;
        x     = '0;
        y     = '0;
        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // NAND
        drive(3'b001, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b1);
        start = 1'b0;
        wait_idle(0, "nand");

        // XOR to zero, then AND on the very next edge
        drive(3'b100, 16'hA5A5, 16'hA5A5, 16'h0000, 1'b1);
        drive(3'b000, 16'h0001, 16'h0003, 16'h0001, 1'b1);
        start = 1'b0;
        wait_idle(0, "b2b");

        // Remaining single-cycle ops back to back
        drive(3'b010, 16'h1234, 16'h00F0, 16'h12F4, 1'b1);
        drive(3'b011, 16'h1234, 16'h00F0, 16'hED0B, 1'b1);
        drive(3'b101, 16'h00FF, 16'h0F0F, 16'hF00F, 1'b1);
        start = 1'b0;
        wait_idle(0, "or_nor_xnor");

        // POPCNT
        drive(3'b110, 16'h8001, 16'hFFFF, 16'h0002, 1'b1);
        start = 1'b0;
        wait_idle(16, "pop_8001");
        drive(3'b110, 16'hFFFF, 16'h0000, 16'h0010, 1'b1);
        start = 1'b0;
        wait_idle(16, "pop_ffff");
        drive(3'b110, 16'h0000, 16'h1234, 16'h0000, 1'b1);
        start = 1'b0;
        wait_idle(16, "pop_0");

        // ROTL
        drive(3'b111, 16'h8001, 16'h0004, 16'h0018, 1'b1);
        start = 1'b0;
        wait_idle(4, "rotl4");
        drive(3'b111, 16'h8001, 16'h0010, 16'h8001, 1'b1);
        start = 1'b0;
        wait_idle(0, "rotl0");
        drive(3'b111, 16'h8001, 16'h000F, 16'hC000, 1'b1);
        start = 1'b0;
        wait_idle(15, "rotl15");

        // Start and operand changes while BUSY must be ignored
        drive(3'b110, 16'h00FF, 16'h0F0F, 16'h0008, 1'b1);
        fork
            wait_idle(16, "busy_ignore");
            begin
                start = 1'b0;
                repeat (3) @(negedge clk);
                start = 1'b1;
                op    = 3'b000;
                x     = 16'hFFFF;
                y     = 16'hFFFF;
                repeat (2) @(negedge clk);
                start = 1'b0;
            end
        join

        // Reset in the middle of a POPCNT: aborted, no done
        drive(3'b110, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(3'b011, 16'h0000, 16'h0000, 16'hFFFF, 1'b1);
        start = 1'b0;
        wait_idle(0, "nor_after_reset");

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", W'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
